// File: rtl/uart_cmd_decoder_pkg.sv
// +----------------------------------------------------------------------+
// | uart_cmd_decoder_pkg : shared constants, state encoding and helpers  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_cmd_decoder_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h6B;
  localparam logic [7:0] DEF_NACK_BYTE = 8'h15;

  localparam logic [7:0] CMD_TURN_ON  = 8'h6E;
  localparam logic [7:0] CMD_TURN_OFF = 8'h55;
  localparam logic [7:0] CMD_TOGGLE   = 8'hC3;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_GET_CMD      = 3'd1,
    ST_GET_LEN      = 3'd2,
    ST_GET_PAY      = 3'd3,
    ST_GET_CHK      = 3'd4,
    ST_SEND_REPLY   = 3'd5,
    ST_WAIT_BUSY_HI = 3'd6,
    ST_WAIT_BUSY_LO = 3'd7
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_reply_ctrl.sv
// +----------------------------------------------------------------------+
// | uart_reply_ctrl : sends one ACK/NACK byte through uart_tx handshake  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_reply_ctrl
  import uart_cmd_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] reply_byte,
  input  logic       tx_busy,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
  output logic       busy
);

  state_t     state;
  logic [7:0] byte_r;
  logic [1:0] wcnt;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      byte_r     <= 8'h00;
      wcnt       <= 2'd0;
      data_to_tx <= 8'h00;
      start_tx   <= 1'b0;
    end else begin
      start_tx <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            byte_r <= reply_byte;
            state  <= ST_SEND_REPLY;
          end
        end
        ST_SEND_REPLY: begin
          if (!tx_busy) begin
            data_to_tx <= byte_r;
            start_tx   <= 1'b1;
            wcnt       <= 2'd0;
            state      <= ST_WAIT_BUSY_HI;
          end
        end
        // Give up after four cycles if uart_tx never acknowledges.
        ST_WAIT_BUSY_HI: begin
          if (tx_busy)
            state <= ST_WAIT_BUSY_LO;
          else if (wcnt == 2'd3)
            state <= ST_IDLE;
          else
            wcnt <= wcnt + 2'd1;
        end
        ST_WAIT_BUSY_LO: begin
          if (!tx_busy)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// +----------------------------------------------------------------------+
// | uart_cmd_decoder : framed command parser with checksum and timeout   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [7:0] ACK_BYTE    = DEF_ACK_BYTE,
  parameter logic [7:0] NACK_BYTE   = DEF_NACK_BYTE,
  parameter int         MAX_LEN     = 4,
  parameter int         TIMEOUT_CYC = 24000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_received,
  input  logic        rx_done,
  input  logic        parity_error,
  input  logic        tx_busy,
  output logic [7:0]  data_to_tx,
  output logic        start_tx,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [7:0]    chk;
  logic [7:0]    code_r;
  logic [2:0]    len_r;
  logic [2:0]    idx;
  logic [31:0]   pay_r;
  logic [TW-1:0] tcnt;
  logic          reply_req;
  logic [7:0]    reply_byte;
  logic          reply_busy;

  uart_reply_ctrl u_reply (
    .clk        (clk),
    .reset      (reset),
    .req        (reply_req),
    .reply_byte (reply_byte),
    .tx_busy    (tx_busy),
    .data_to_tx (data_to_tx),
    .start_tx   (start_tx),
    .busy       (reply_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      chk         <= 8'h00;
      code_r      <= 8'h00;
      len_r       <= 3'd0;
      idx         <= 3'd0;
      pay_r       <= 32'h0;
      tcnt        <= '0;
      reply_req   <= 1'b0;
      reply_byte  <= 8'h00;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      cmd_len     <= 3'd0;
      cmd_payload <= 32'h0;
      err_count   <= 8'h00;
    end else begin
      cmd_valid <= 1'b0;
      reply_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done && !parity_error && data_received == SYNC_BYTE) begin
            state <= ST_GET_CMD;
            tcnt  <= '0;
            idx   <= 3'd0;
            pay_r <= 32'h0;
          end
        end
        ST_GET_CMD, ST_GET_LEN, ST_GET_PAY, ST_GET_CHK: begin
          if (rx_done && parity_error) begin
            state     <= ST_IDLE;
            err_count <= sat_inc(err_count);
          end else if (rx_done) begin
            tcnt <= '0;
            case (state)
              ST_GET_CMD: begin
                code_r <= data_received;
                chk    <= data_received;
                state  <= ST_GET_LEN;
              end
              ST_GET_LEN: begin
                chk <= chk ^ data_received;
                if (data_received > 8'(MAX_LEN)) begin
                  reply_byte <= NACK_BYTE;
                  reply_req  <= 1'b1;
                  state      <= ST_SEND_REPLY;
                end else begin
                  len_r <= data_received[2:0];
                  state <= (data_received == 8'h00) ? ST_GET_CHK : ST_GET_PAY;
                end
              end
              ST_GET_PAY: begin
                pay_r[{idx[1:0], 3'b000} +: 8] <= data_received;
                chk <= chk ^ data_received;
                idx <= idx + 3'd1;
                if (idx + 3'd1 == len_r)
                  state <= ST_GET_CHK;
              end
              default: begin
                if (data_received == chk) begin
                  cmd_valid   <= 1'b1;
                  cmd_code    <= code_r;
                  cmd_len     <= len_r;
                  cmd_payload <= pay_r;
                  reply_byte  <= ACK_BYTE;
                end else begin
                  reply_byte <= NACK_BYTE;
                  err_count  <= sat_inc(err_count);
                end
                reply_req <= 1'b1;
                state     <= ST_SEND_REPLY;
              end
            endcase
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= ST_IDLE;
            err_count <= sat_inc(err_count);
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        // Held here until the reply handshake drains; stray SYNCs count as drops.
        ST_SEND_REPLY: begin
          if (rx_done && data_received == SYNC_BYTE)
            err_count <= sat_inc(err_count);
          if (!reply_req && !reply_busy)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// +----------------------------------------------------------------------+
// | tb_uart_cmd_decoder : vector table plus scoreboard for the decoder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_received = 8'h00;
  logic        rx_done = 1'b0;
  logic        parity_error = 1'b0;
  logic        tx_busy;
  logic [7:0]  data_to_tx;
  logic        start_tx;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic [7:0]  err_count;

  uart_cmd_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .tx_busy       (tx_busy),
    .data_to_tx    (data_to_tx),
    .start_tx      (start_tx),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_len       (cmd_len),
    .cmd_payload   (cmd_payload),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Simple uart_tx stand-in: busy for 8 cycles after each start_tx.
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  logic quiet_tx = 1'b0;
  always @(posedge clk) begin
    if (start_tx && !quiet_tx) busy_cnt <= 8;
    else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  typedef struct {
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] pay;
  } cmd_t;

  typedef struct {
    logic [63:0] frame;
    int          n;
    logic [7:0]  par;
    bit          valid;
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] pay;
    bit          reply;
    logic [7:0]  rbyte;
    int          err_inc;
  } vec_t;

  cmd_t       cmd_q[$];
  logic [7:0] rep_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] err_exp = 8'h00;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic bump_err();
    if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    @(negedge clk);
    data_received = b;
    parity_error  = p;
    rx_done       = 1'b1;
    @(negedge clk);
    rx_done      = 1'b0;
    parity_error = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [7:0] code, input logic [2:0] len, input logic [31:0] pay);
    cmd_t c;
    c.code = code;
    c.len  = len;
    c.pay  = pay;
    cmd_q.push_back(c);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (cmd_valid) begin
        n_vec++;
        if (cmd_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_cmd_valid: got code=%h len=%0d pay=%h, expected none", cmd_code, cmd_len, cmd_payload);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          if (cmd_code !== e.code || cmd_len !== e.len || cmd_payload !== e.pay) begin
            n_err++;
            $display("FAIL cmd_fields: got %h/%0d/%h, expected %h/%0d/%h", cmd_code, cmd_len, cmd_payload, e.code, e.len, e.pay);
          end
        end
      end
      if (start_tx) begin
        n_vec++;
        if (rep_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_start_tx: got data_to_tx=%h, expected none", data_to_tx);
        end else begin
          logic [7:0] r;
          r = rep_q.pop_front();
          if (data_to_tx !== r) begin
            n_err++;
            $display("FAIL reply_byte: got %h, expected %h", data_to_tx, r);
          end
        end
      end
    end
  end

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic settle_and_check(input string name, input int idx);
    repeat (30) @(negedge clk);
    check({name, "_err_count"}, idx, 32'(err_count), 32'(err_exp));
    check({name, "_cmd_pending"}, idx, cmd_q.size(), 0);
    check({name, "_reply_pending"}, idx, rep_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{64'hA5_6E_00_6E_00_00_00_00, 4, 8'h00, 1, 8'h6E, 3'd0, 32'h0000_0000, 1, 8'h6B, 0};
    vecs[1] = '{64'hA5_10_02_34_12_34_00_00, 6, 8'h00, 1, 8'h10, 3'd2, 32'h0000_1234, 1, 8'h6B, 0};
    vecs[2] = '{64'hA5_10_01_AA_00_00_00_00, 5, 8'h00, 0, 8'h00, 3'd0, 32'h0,         1, 8'h15, 1};
    vecs[3] = '{64'hA5_10_05_00_00_00_00_00, 3, 8'h00, 0, 8'h00, 3'd0, 32'h0,         1, 8'h15, 0};
    vecs[4] = '{64'hA5_C3_01_A5_67_00_00_00, 5, 8'h00, 1, 8'hC3, 3'd1, 32'h0000_00A5, 1, 8'h6B, 0};
    vecs[5] = '{64'hA5_55_04_11_22_33_44_15, 8, 8'h00, 1, 8'h55, 3'd4, 32'h4433_2211, 1, 8'h6B, 0};
    vecs[6] = '{64'h12_A5_6E_00_00_00_00_00, 3, 8'h02, 0, 8'h00, 3'd0, 32'h0,         0, 8'h00, 0};
    vecs[7] = '{64'hA5_6E_00_00_00_00_00_00, 3, 8'h04, 0, 8'h00, 3'd0, 32'h0,         0, 8'h00, 1};
    vecs[8] = '{64'hA5_6E_00_6F_00_00_00_00, 4, 8'h00, 0, 8'h00, 3'd0, 32'h0,         1, 8'h15, 1};

    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_valid", 0, 32'(cmd_valid), 0);
    check("rst_cmd_code", 0, 32'(cmd_code), 0);
    check("rst_cmd_payload", 0, cmd_payload, 0);
    check("rst_start_tx", 0, 32'(start_tx), 0);
    check("rst_err_count", 0, 32'(err_count), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].valid) push_cmd(vecs[i].code, vecs[i].len, vecs[i].pay);
      if (vecs[i].reply) rep_q.push_back(vecs[i].rbyte);
      for (int k = 0; k < vecs[i].err_inc; k++) bump_err();
      for (int k = 0; k < vecs[i].n; k++)
        send_byte(vecs[i].frame[63-8*k -: 8], vecs[i].par[k]);
      settle_and_check("vec", i);
    end

    // SYNC arriving while the ACK is still in flight counts as a dropped frame.
    push_cmd(8'h6E, 3'd0, 32'h0);
    rep_q.push_back(8'h6B);
    send_byte(8'hA5, 1'b0); send_byte(8'h6E, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h6E, 1'b0);
    send_byte(8'hA5, 1'b0);
    bump_err();
    settle_and_check("sync_in_reply", 0);

    // uart_tx never raises busy: reply gives up, next frame still decodes.
    quiet_tx = 1'b1;
    push_cmd(8'h55, 3'd0, 32'h0);
    rep_q.push_back(8'h6B);
    send_byte(8'hA5, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    quiet_tx = 1'b0;
    push_cmd(8'hC3, 3'd0, 32'h0);
    rep_q.push_back(8'h6B);
    send_byte(8'hA5, 1'b0); send_byte(8'hC3, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hC3, 1'b0);
    settle_and_check("no_busy_ack", 0);

    // Long but legal gap inside a frame.
    push_cmd(8'h6E, 3'd0, 32'h0);
    rep_q.push_back(8'h6B);
    send_byte(8'hA5, 1'b0);
    repeat (23900) @(negedge clk);
    send_byte(8'h6E, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h6E, 1'b0);
    settle_and_check("near_timeout", 0);

    // Gap past the timeout: frame aborted, trailing bytes ignored.
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
    repeat (24001) @(negedge clk);
    send_byte(8'h6E, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h6E, 1'b0);
    bump_err();
    settle_and_check("timeout", 0);

    // Drive err_count into saturation with parity aborts.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b1);
      bump_err();
    end
    settle_and_check("saturate", 0);
    check("saturate_value", 0, 32'(err_count), 32'hFF);

    // Reset mid-payload with uart_tx held busy.
    hold_busy = 1'b1;
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h34, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_cmd_code", 0, 32'(cmd_code), 0);
    check("async_rst_cmd_len", 0, 32'(cmd_len), 0);
    check("async_rst_data_to_tx", 0, 32'(data_to_tx), 0);
    check("async_rst_err_count", 0, 32'(err_count), 0);
    err_exp = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_cmd(8'h55, 3'd0, 32'h0);
    rep_q.push_back(8'h6B);
    send_byte(8'hA5, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check("busy_hold_cmd_done", 0, cmd_q.size(), 0);
    check("busy_hold_reply_waiting", 0, rep_q.size(), 1);
    check("busy_hold_cmd_code", 0, 32'(cmd_code), 32'h55);
    hold_busy = 1'b0;
    settle_and_check("post_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
